// File: rtl/lcd_pattern_gen.sv
// Test-pattern source for lcd_driver: colour bars, a bouncing red box, or solid white.
// Define PATTERN_GRID_EN to overlay a grey 32-pixel grid on the bar modes.
module lcd_pattern_gen #(
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [15:0] lcd_id,
  input  logic [1:0]  mode,
  input  logic [10:0] pixel_row,
  input  logic [10:0] pixel_line,
  output logic [23:0] pixel_data,
  output logic [7:0]  frame_cnt
);

  localparam logic [11:0] C_SIZE = 12'(BOX_SIZE);
  localparam logic [11:0] C_STEP = 12'(BOX_STEP);
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_BOX   = 2'd1,
    MODE_MIXED = 2'd2,
    MODE_WHITE = 2'd3
  } patMode_t;

  patMode_t    r_mode;
  logic [11:0] r_hDisp, r_vDisp;
  logic [11:0] r_boxX, r_boxY;
  logic        r_dirX, r_dirY;
  logic [23:0] r_pixelData;
  logic [7:0]  r_frameCnt;

  logic [11:0] w_x, w_y;
  logic [11:0] w_decH, w_decV;
  logic        w_frameEnd;
  logic        w_inRange, w_inBox;
  logic [11:0] w_barW;
  logic [2:0]  w_barIdx;
  logic [23:0] w_barColour, w_barLayer, w_pixelNext;
  logic [11:0] w_nextBoxX, w_nextBoxY;
  logic        w_nextDirX, w_nextDirY;

  assign w_x = {1'b0, pixel_row};
  assign w_y = {1'b0, pixel_line};

  always_comb begin
    w_decH = 12'd480;
    w_decV = 12'd272;
    case (lcd_id)
      16'h7084: begin w_decH = 12'd800;  w_decV = 12'd480; end
      16'h7016: begin w_decH = 12'd1024; w_decV = 12'd600; end
      16'h1018: begin w_decH = 12'd1280; w_decV = 12'd800; end
      default:  ;
    endcase
  end

  assign w_frameEnd = (w_x == r_hDisp - 12'd1) && (w_y == r_vDisp - 12'd1);
  assign w_inRange  = (w_x < r_hDisp) && (w_y < r_vDisp);
  assign w_inBox    = (w_x >= r_boxX) && (w_x < r_boxX + C_SIZE) &&
                      (w_y >= r_boxY) && (w_y < r_boxY + C_SIZE);
  assign w_barW     = r_hDisp >> 3;

  // Smallest k with x < (k+1)*W wins; anything past 7*W falls into bar 7.
  always_comb begin
    w_barIdx = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (w_x < w_barW * 12'(k + 1)) w_barIdx = 3'(k);
    end
  end

  always_comb begin
    w_barColour = 24'h000000;
    case (w_barIdx)
      3'd0: w_barColour = 24'hFFFFFF;
      3'd1: w_barColour = 24'hFFFF00;
      3'd2: w_barColour = 24'h00FFFF;
      3'd3: w_barColour = 24'h00FF00;
      3'd4: w_barColour = 24'hFF00FF;
      3'd5: w_barColour = 24'hFF0000;
      3'd6: w_barColour = 24'h0000FF;
      default: w_barColour = 24'h000000;
    endcase
  end

`ifdef PATTERN_GRID_EN
  assign w_barLayer = ((w_x[4:0] == 5'd0) || (w_y[4:0] == 5'd0)) ? 24'h808080 : w_barColour;
`else
  assign w_barLayer = w_barColour;
`endif

  always_comb begin
    w_pixelNext = 24'h000000;
    if (w_inRange) begin
      case (r_mode)
        MODE_BARS:  w_pixelNext = w_barLayer;
        MODE_BOX:   w_pixelNext = w_inBox ? C_RED : 24'h000000;
        MODE_MIXED: w_pixelNext = w_inBox ? C_RED : w_barLayer;
        default:    w_pixelNext = C_WHITE;
      endcase
    end
  end

  // One axis of box motion against the newly decoded limit, so a shrinking panel clamps the box at once.
  function automatic logic [12:0] stepAxis(input logic [11:0] pos, input logic dir,
                                           input logic [11:0] lim);
    if (dir) begin
      if (pos + C_STEP + C_SIZE >= lim) return {1'b0, lim - C_SIZE};
      else                              return {1'b1, pos + C_STEP};
    end else begin
      if (pos <= C_STEP)               return {1'b1, 12'd0};
      else if (pos + C_SIZE > lim)     return {1'b0, lim - C_SIZE};
      else                             return {1'b0, pos - C_STEP};
    end
  endfunction

  assign {w_nextDirX, w_nextBoxX} = stepAxis(r_boxX, r_dirX, w_decH);
  assign {w_nextDirY, w_nextBoxY} = stepAxis(r_boxY, r_dirY, w_decV);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixelData <= 24'h000000;
      r_frameCnt  <= 8'd0;
      r_boxX      <= 12'd0;
      r_boxY      <= 12'd0;
      r_dirX      <= 1'b1;
      r_dirY      <= 1'b1;
      r_mode      <= MODE_BARS;
      r_hDisp     <= 12'd480;
      r_vDisp     <= 12'd272;
    end else begin
      r_pixelData <= w_pixelNext;
      if (w_frameEnd) begin
        r_frameCnt <= r_frameCnt + 8'd1;
        r_mode     <= patMode_t'(mode);
        r_hDisp    <= w_decH;
        r_vDisp    <= w_decV;
        r_boxX     <= w_nextBoxX;
        r_boxY     <= w_nextBoxY;
        r_dirX     <= w_nextDirX;
        r_dirY     <= w_nextDirY;
      end
    end
  end

  assign pixel_data = r_pixelData;
  assign frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: bars, box motion and bounce, shadowed resolution
// change, frame counter wrap and asynchronous reset.
module tb_lcd_pattern_gen;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] lcd_id = 16'h4342;
  logic [1:0]  mode = 2'd0;
  logic [10:0] pixel_row = 11'd0;
  logic [10:0] pixel_line = 11'd0;
  logic [23:0] pixel_data;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad = 0;

  always #5 pclk = ~pclk;

  lcd_pattern_gen #(.BOX_SIZE(32), .BOX_STEP(2)) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .lcd_id(lcd_id),
    .mode(mode),
    .pixel_row(pixel_row),
    .pixel_line(pixel_line),
    .pixel_data(pixel_data),
    .frame_cnt(frame_cnt)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y);
    pixel_row  = 11'(x);
    pixel_line = 11'(y);
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] exp);
    total++;
    assert (pixel_data === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: pixel_data=%h expected %h", tag, pixel_data, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [7:0] exp);
    total++;
    assert (frame_cnt === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: frame_cnt=%0d expected %0d", tag, frame_cnt, exp);
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
    applyStimulus(x, y);
    checkOutput(tag, exp);
  endtask

  // Holding the coordinates on the last pixel produces one frame end per clock.
  task automatic frameEnds(input int n, input int x, input int y);
    pixel_row  = 11'(x);
    pixel_line = 11'(y);
    repeat (n) tick();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values, observed without any clock edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_pixel", 24'h000000);
    checkCount("reset_cnt", 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Colour bars at 480x272, W = 60
    probe("bar1_x60", 60, 10, 24'hFFFF00);
    probe("bar0_x10", 10, 10, 24'hFFFFFF);
    probe("bar0_x59", 59, 10, 24'hFFFFFF);
    probe("bar2_x120", 120, 10, 24'h00FFFF);
    probe("bar3_x180", 180, 10, 24'h00FF00);
    probe("bar4_x240", 240, 10, 24'hFF00FF);
    probe("bar5_x300", 300, 10, 24'hFF0000);
    probe("bar6_x419", 419, 10, 24'h0000FF);
    probe("bar7_x420", 420, 10, 24'h000000);
    probe("bar7_x479", 479, 10, 24'h000000);
    probe("oor_x480", 480, 10, 24'h000000);
    probe("oor_y272", 100, 272, 24'h000000);
`ifdef PATTERN_GRID_EN
    probe("grid_x32", 32, 5, 24'h808080);
`else
    probe("grid_x32", 32, 5, 24'hFFFFFF);
`endif

    // Box on black, five frames from reset -> (10,10)
    mode = 2'd1;
    frameEnds(5, 479, 271);
    checkCount("cnt_5", 8'd5);
    probe("box5_in", 10, 10, 24'hFF0000);
    probe("box5_left", 9, 10, 24'h000000);
    probe("box5_far", 41, 41, 24'hFF0000);
    probe("box5_right", 42, 10, 24'h000000);
    probe("box5_below", 10, 42, 24'h000000);

    // 223 frames -> (446,34) moving right; y already bounced at 240
    frameEnds(218, 479, 271);
    checkCount("cnt_223", 8'd223);
    probe("box223_in", 446, 34, 24'hFF0000);
    probe("box223_left", 445, 34, 24'h000000);
    probe("box223_far", 477, 65, 24'hFF0000);
    probe("box223_right", 478, 34, 24'h000000);

    // Right edge clamp to 448, then back to 446
    frameEnds(1, 479, 271);
    probe("box224_in", 448, 32, 24'hFF0000);
    probe("box224_left", 447, 32, 24'h000000);
    probe("box224_edge", 479, 63, 24'hFF0000);
    frameEnds(1, 479, 271);
    probe("box225_in", 446, 30, 24'hFF0000);
    probe("box225_left", 445, 30, 24'h000000);

    // Solid white, then bars with box at (442,26)
    mode = 2'd3;
    frameEnds(1, 479, 271);
    probe("white_in", 100, 100, 24'hFFFFFF);
    probe("white_oorx", 480, 0, 24'h000000);
    probe("white_oory", 0, 272, 24'h000000);
    mode = 2'd2;
    frameEnds(1, 479, 271);
    probe("mixed_box", 442, 26, 24'hFF0000);
    probe("mixed_bar1", 60, 26, 24'hFFFF00);
    probe("mixed_bar7", 474, 26, 24'h000000);

    // Frame counter wrap
    frameEnds(28, 479, 271);
    checkCount("cnt_255", 8'd255);
    frameEnds(1, 479, 271);
    checkCount("cnt_wrap", 8'd0);

    // Asynchronous reset mid-line
    applyStimulus(60, 10);
    applyStimulus(61, 10);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pixel", 24'h000000);
    checkCount("async_rst_cnt", 8'd0);
    #1 rst_n = 1'b1;
    probe("post_rst_bar1", 60, 10, 24'hFFFF00);
    mode = 2'd1;
    frameEnds(1, 479, 271);
    probe("post_rst_box", 2, 2, 24'hFF0000);
    probe("post_rst_left", 1, 2, 24'h000000);
    probe("post_rst_above", 2, 1, 24'h000000);
    probe("post_rst_far", 33, 33, 24'hFF0000);
    probe("post_rst_right", 34, 33, 24'h000000);

    // 800x480 for 350 frames -> box (700,196), then shrink to 480x272
    pulseReset();
    lcd_id = 16'h7084;
    mode = 2'd1;
    frameEnds(1, 479, 271);
    frameEnds(349, 799, 479);
    checkCount("cnt_350", 8'd94);
    probe("big_box", 700, 196, 24'hFF0000);
    probe("big_left", 699, 196, 24'h000000);
    probe("big_far", 731, 227, 24'hFF0000);
    probe("big_right", 732, 196, 24'h000000);
    lcd_id = 16'h4342;
    probe("shadow_hold_pix", 479, 271, 24'h000000);
    checkCount("shadow_hold_cnt", 8'd94);
    probe("shadow_hold_box", 700, 196, 24'hFF0000);
    frameEnds(1, 799, 479);
    checkCount("cnt_shrink", 8'd95);
    probe("clamp_box", 448, 194, 24'hFF0000);
    probe("clamp_left", 447, 194, 24'h000000);
    probe("clamp_edge", 479, 225, 24'hFF0000);
    probe("clamp_oor", 480, 194, 24'h000000);
    frameEnds(1, 479, 271);
    checkCount("cnt_small", 8'd96);
    probe("small_box", 446, 192, 24'hFF0000);
    probe("small_right", 478, 192, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
